// File: rtl/t05_spi_pkg.sv
// Shared types and helpers for the SPI bit packer output stage.
package t05_spi_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_CLK_DIV = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_LOW,
        TX_HIGH
    } tx_state_t;

    // Left-justify the n collected bits and fill the low end with pad.
    function automatic logic [BYTE_W-1:0] pad_byte(
        input logic [BYTE_W-2:0] sr,
        input logic [2:0]        n,
        input logic              pad
    );
        logic [BYTE_W-1:0] data;
        logic [BYTE_W-1:0] fill;
        data = {1'b0, sr} << (3'd0 - n);
        fill = pad ? (8'hFF >> n) : '0;
        return data | fill;
    endfunction

endpackage

// File: rtl/t05_spi_bit_packer_fifo.sv
// Small synchronous byte FIFO; head entry is visible on dout without a pop.
module t05_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/t05_spi_bit_packer.sv
// Packs a serial bit stream MSB-first into bytes, buffers them and
// shifts them out as an SPI mode-0 master; flush pads and drains.
module t05_spi_bit_packer
    import t05_spi_pkg::*;
#(
    parameter int   CLK_DIV    = DEF_CLK_DIV,
    parameter int   FIFO_DEPTH = 4,
    parameter logic PAD_BIT    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        flush,
    output logic        ready,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [31:0] byte_count,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    tx_state_t         state;
    tx_state_t         state_d;
    logic [BYTE_W-2:0] shreg;
    logic [2:0]        cnt;
    logic              flush_pending;
    logic              armed;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] push_data;
    logic [BYTE_W-1:0] fifo_dout;
    logic [BYTE_W-1:0] txreg;
    logic [2:0]        bitidx;
    logic [DW-1:0]     divcnt;
    logic              accept;
    logic              pad_push;
    logic              fin;
    logic              div_end;

    // armed keeps ready low during and right after reset regardless of en
    assign ready    = armed && en && !fifo_full && !flush_pending;
    assign accept   = bit_valid && ready;
    assign pad_push = flush_pending && (cnt != 3'd0) && !fifo_full;
    assign push     = (accept && cnt == 3'd7) || pad_push;
    assign push_data = pad_push ? pad_byte(shreg, cnt, PAD_BIT)
                                : {shreg, bit_in};
    assign fin = (flush_pending || (flush && !accept)) && (cnt == 3'd0)
              && fifo_empty && (state == TX_IDLE);

    assign div_end = (divcnt == DIV_LAST);
    assign sclk    = (state == TX_HIGH);
    assign cs_n    = (state == TX_IDLE);

    t05_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg         <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            done          <= 1'b0;
            armed         <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                shreg <= {shreg[BYTE_W-3:0], bit_in};
                cnt   <= cnt + 3'd1;
            end else if (pad_push) begin
                cnt <= 3'd0;
            end
            done <= fin;
            if (fin)        flush_pending <= 1'b0;
            else if (flush) flush_pending <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        unique case (state)
            TX_IDLE: if (!fifo_empty) state_d = TX_LOAD;
            TX_LOAD: begin
                pop     = 1'b1;
                state_d = TX_LOW;
            end
            TX_LOW:  if (div_end) state_d = TX_HIGH;
            TX_HIGH: begin
                if (div_end) begin
                    if (bitidx != 3'd0)   state_d = TX_LOW;
                    else if (!fifo_empty) state_d = TX_LOAD;
                    else                  state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= TX_IDLE;
            txreg      <= '0;
            bitidx     <= '0;
            divcnt     <= '0;
            mosi       <= 1'b0;
            byte_count <= '0;
        end else begin
            state <= state_d;
            if (state_d != state) divcnt <= '0;
            else                  divcnt <= divcnt + 1'b1;
            if (state == TX_LOAD) begin
                txreg  <= fifo_dout;
                mosi   <= fifo_dout[BYTE_W-1];
                bitidx <= 3'd7;
            end
            if (state == TX_HIGH && div_end) begin
                if (bitidx != 3'd0) begin
                    bitidx <= bitidx - 3'd1;
                    mosi   <= txreg[bitidx - 3'd1];
                end else begin
                    byte_count <= byte_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_t05_spi_bit_packer.sv
// Bench for the SPI bit packer: SPI slave monitor plus a bit-queue
// reference model, directed scenarios and a randomized stream.
module tb_t05_spi_bit_packer;

    localparam int   CLK_DIV    = 4;
    localparam int   FIFO_DEPTH = 4;
    localparam logic PAD_BIT    = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        bit_in;
    logic        bit_valid;
    logic        flush;
    logic        ready;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [31:0] byte_count;
    logic        done;

    always #5 clk = ~clk;

    t05_spi_bit_packer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PAD_BIT    (PAD_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .ready      (ready),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .byte_count (byte_count),
        .done       (done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference model state
    bit          bq[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    bit          pend_m;
    bit          done_exp;
    int          rx_bits;
    logic [7:0]  rx_shift;
    logic [31:0] rx_count;
    int          hi_run;
    int          lo_run;
    logic        prev_sclk;
    logic        prev_mosi;
    logic        prev_cs;
    int          done_seen;
    int          rise_seen;
    int          cs_rises;
    int          ready_low_seen;
    logic        acc;
    logic        fin;
    logic [7:0]  nb;

    always @(negedge clk) begin
        if (rst) begin
            bq.delete();
            exp_q.delete();
            log_q.delete();
            pend_m = 0;
            done_exp = 0;
            rx_bits = 0;
            rx_shift = '0;
            rx_count = '0;
            hi_run = 0;
            lo_run = 0;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            prev_cs = 1'b1;
            done_seen = 0;
            rise_seen = 0;
            cs_rises = 0;
            ready_low_seen = 0;
        end else begin
            if (sclk && !prev_sclk) begin
                chk("rise_low_len", lo_run,
                    rx_bits == 0 ? CLK_DIV + 1 : CLK_DIV);
                chk("cs_at_rise", cs_n, 0);
                rx_shift = {rx_shift[6:0], mosi};
                rx_bits++;
                rise_seen++;
            end
            if (sclk) chk("mosi_stable", mosi, prev_mosi);
            if (!sclk && prev_sclk) begin
                chk("high_len", hi_run, CLK_DIV);
                if (rx_bits == 8) begin
                    log_q.push_back(rx_shift);
                    rx_count++;
                    chk("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0)
                        chk("rx_byte", rx_shift, exp_q.pop_front());
                    rx_bits = 0;
                end
            end
            if (!prev_cs && cs_n) begin
                cs_rises++;
                chk("cs_rise_boundary", rx_bits, 0);
            end
            if (sclk) begin
                hi_run++;
                lo_run = 0;
            end else begin
                hi_run = 0;
                lo_run = cs_n ? 0 : lo_run + 1;
            end
            if (cs_n) chk("sclk_idle", sclk, 0);
            chk("byte_count", byte_count, rx_count);
            chk("done", done, done_exp);
            if (done) done_seen++;
            if (!en || pend_m) chk("ready_blocked", ready, 0);
            if (en && !pend_m && !ready) ready_low_seen++;

            acc = bit_valid && ready;
            fin = (pend_m || (flush && !acc)) && bq.size() == 0
                  && exp_q.size() == 0 && cs_n;
            if (acc) bq.push_back(bit_in);
            if (flush && !pend_m && !fin) begin
                pend_m = 1;
                if (bq.size() > 0)
                    while (bq.size() < 8) bq.push_back(PAD_BIT);
            end
            if (bq.size() == 8) begin
                nb = '0;
                for (int i = 0; i < 8; i++) nb = {nb[6:0], bq[i]};
                exp_q.push_back(nb);
                bq.delete();
            end
            if (fin) pend_m = 0;
            done_exp = fin;
            prev_sclk = sclk;
            prev_mosi = mosi;
            prev_cs = cs_n;
        end
    end

    task automatic do_reset();
        en = 1'b0;
        bit_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic f);
        int g;
        bit_in = b;
        bit_valid = 1'b1;
        flush = f;
        g = 0;
        @(negedge clk);
        while (!ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("send_accept", g < 5000, 1);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_quiet(input int maxc);
        int c;
        c = 0;
        while (!(exp_q.size() == 0 && bq.size() == 0 && cs_n
                 && !pend_m && rx_bits == 0) && c < maxc) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("quiet_reached", c < maxc, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_sclk"}, sclk, 0);
        chk({tag, "_mosi"}, mosi, 0);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_byte_count"}, byte_count, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sent [5];
        int c;
        rst = 1'b1;
        en = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");

        // single byte 0xB2
        do_reset();
        en = 1'b1;
        send_byte(8'hB2);
        wait_quiet(2000);
        chk("b2_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("b2_byte", log_q[0], 8'hB2);
        chk("b2_byte_count", byte_count, 1);
        chk("b2_cs_rises", cs_rises, 1);
        chk("b2_rises", rise_seen, 8);
        chk("b2_no_done", done_seen, 0);

        // 40 continuous random bits, back-to-back bytes
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sent[k] = 8'($urandom);
            send_byte(sent[k]);
        end
        wait_quiet(5000);
        chk("s40_count", log_q.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < log_q.size()) chk("s40_byte", log_q[k], sent[k]);
        chk("s40_byte_count", byte_count, 5);
        chk("s40_cs_rises", cs_rises, 1);
        chk("s40_ready_dropped", ready_low_seen > 0, 1);

        // partial byte 1,1,1 then flush
        do_reset();
        en = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        pulse_flush();
        wait_quiet(2000);
        chk("e0_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("e0_byte", log_q[0], 8'hE0);
        chk("e0_done_once", done_seen, 1);
        chk("e0_byte_count", byte_count, 1);

        // flush with nothing buffered
        do_reset();
        en = 1'b1;
        pulse_flush();
        chk("empty_flush_done", done, 1);
        wait_quiet(100);
        chk("empty_flush_once", done_seen, 1);
        chk("empty_flush_no_sclk", rise_seen, 0);

        // flush coincident with 8th bit of 0xFF
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_quiet(2000);
        chk("ff_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("ff_byte", log_q[0], 8'hFF);
        chk("ff_byte_count", byte_count, 1);
        chk("ff_done_once", done_seen, 1);

        // reset in the middle of a byte
        do_reset();
        en = 1'b1;
        send_byte(8'h3C);
        c = 0;
        while (rise_seen < 3 && c < 2000) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("mid_rise3", c < 2000, 1);
        #1 rst = 1'b1;
        #1 chk_reset_outs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send_byte(8'hA5);
        wait_quiet(2000);
        chk("a5_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("a5_byte", log_q[0], 8'hA5);
        chk("a5_byte_count", byte_count, 1);

        // randomized stream with gaps, en toggling and flushes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            bit_in = 1'($urandom);
            flush = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        flush = 1'b0;
        en = 1'b1;
        pulse_flush();
        wait_quiet(20000);
        chk("rand_done_seen", done_seen > 0, 1);
        chk("rand_all_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
